midi_note_decoder: RTL and testbench

Monophonic MIDI channel-message decoder that drives the synth voice's control inputs (`NOTE`, `form`, `pulse_width`) plus a gate and velocity. It consumes a byte stream from the UART receiver, one byte per `rx_valid` pulse. It parses status, running status, data and realtime bytes, and holds the last decoded voice parameters as registers feeding `top`.

---
 rtl/midi_note_decoder.sv | 119 +++++++++++
 tb/tb_midi_note_decoder.sv | 119 +++++++++++
 2 files changed

// File: rtl/midi_note_decoder.sv
// Monophonic MIDI channel-message decoder: parses status/running-status/data/realtime
// bytes and holds the last note, gate, velocity, waveform and pulse width as registers.
module midi_note_decoder #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter logic [6:0] CC_FORM = 7'd112,
    parameter logic [6:0] CC_PW   = 7'd113
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] NOTE,
    output logic       gate,
    output logic [6:0] velocity,
    output logic [2:0] form,
    output logic [6:0] pulse_width,
    output logic       note_strobe
);

    typedef enum logic [1:0] {S_NONE, S_D1, S_D2} state_t;

    state_t     state, state_nx;
    logic [7:0] status, status_nx;
    logic [6:0] d1, d1_nx;
    logic [7:0] note_nx;
    logic       gate_nx, strobe_nx;
    logic [6:0] vel_nx, pw_nx;
    logic [2:0] form_nx;

    logic       is_rt, is_sys, is_stat, one_byte_msg, on_chan;
    logic [6:0] d2;

    assign is_rt        = rx_data[7:3] == 5'b11111;
    assign is_sys       = rx_data[7:4] == 4'hF;
    assign is_stat      = rx_data[7];
    assign d2           = rx_data[6:0];
    // 0xCn / 0xDn carry a single data byte
    assign one_byte_msg = status[7:5] == 3'b110;
    assign on_chan      = status[3:0] == CHANNEL;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_NONE;
            status      <= 8'h00;
            d1          <= 7'd0;
            NOTE        <= 8'd69;
            gate        <= 1'b0;
            velocity    <= 7'd0;
            form        <= 3'b010;
            pulse_width <= 7'd40;
            note_strobe <= 1'b0;
        end else begin
            state       <= state_nx;
            status      <= status_nx;
            d1          <= d1_nx;
            NOTE        <= note_nx;
            gate        <= gate_nx;
            velocity    <= vel_nx;
            form        <= form_nx;
            pulse_width <= pw_nx;
            note_strobe <= strobe_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        status_nx = status;
        d1_nx     = d1;
        note_nx   = NOTE;
        gate_nx   = gate;
        vel_nx    = velocity;
        form_nx   = form;
        pw_nx     = pulse_width;
        strobe_nx = 1'b0;

        if (rx_valid && !is_rt) begin
            if (is_sys) begin
                status_nx = 8'h00;
                state_nx  = S_NONE;
            end else if (is_stat) begin
                status_nx = rx_data;
                state_nx  = S_D1;
            end else begin
                case (state)
                    S_D1: begin
                        d1_nx    = rx_data[6:0];
                        state_nx = one_byte_msg ? S_D1 : S_D2;
                    end
                    S_D2: begin
                        state_nx = S_D1;
                        if (on_chan) begin
                            case (status[7:4])
                                4'h9, 4'h8: begin
                                    if (status[7:4] == 4'h9 && d2 != 7'd0) begin
                                        note_nx   = {1'b0, d1};
                                        vel_nx    = d2;
                                        gate_nx   = 1'b1;
                                        strobe_nx = 1'b1;
                                    end else if (gate && NOTE == {1'b0, d1}) begin
                                        // only the sounding note may release the gate
                                        gate_nx   = 1'b0;
                                        strobe_nx = 1'b1;
                                    end
                                end
                                4'hB: begin
                                    if (d1 == CC_FORM) form_nx = d2[2:0];
                                    else if (d1 == CC_PW) pw_nx = d2;
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_midi_note_decoder.sv
// Directed bench for midi_note_decoder: byte sequences with hand-computed outputs.
module tb_midi_note_decoder;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] NOTE;
    logic       gate;
    logic [6:0] velocity;
    logic [2:0] form;
    logic [6:0] pulse_width;
    logic       note_strobe;

    int total = 0;
    int bad = 0;
    int strb = 0;

    midi_note_decoder dut (
        .CLK(CLK), .RESET(RESET), .rx_data(rx_data), .rx_valid(rx_valid),
        .NOTE(NOTE), .gate(gate), .velocity(velocity), .form(form),
        .pulse_width(pulse_width), .note_strobe(note_strobe)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (!RESET && note_strobe) strb++;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // bytes go out back-to-back until idle() drops rx_valid
    task automatic tx(input logic [7:0] b);
        @(negedge CLK);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge CLK);
        rx_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic voice(input string tag, input int n, input int g, input int v, input int s);
        chk({tag, ".note"}, int'(NOTE), n);
        chk({tag, ".gate"}, int'(gate), g);
        chk({tag, ".vel"}, int'(velocity), v);
        chk({tag, ".strobes"}, strb, s);
    endtask

    initial begin
        repeat (5) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst.note", int'(NOTE), 69);
        chk("rst.gate", int'(gate), 0);
        chk("rst.vel", int'(velocity), 0);
        chk("rst.form", int'(form), 2);
        chk("rst.pw", int'(pulse_width), 40);
        chk("rst.strobe", int'(note_strobe), 0);

        tx(8'h90); tx(8'h45); tx(8'h64); idle();
        voice("on1", 69, 1, 100, 1);
        chk("on1.strobe_low", int'(note_strobe), 0);
        tx(8'h3C); tx(8'h50); idle();
        voice("run", 60, 1, 80, 2);

        tx(8'h80); tx(8'h45); tx(8'h00); idle();
        voice("off_other", 60, 1, 80, 2);
        tx(8'h90); tx(8'h3C); tx(8'h00); idle();
        voice("off_v0", 60, 0, 80, 3);

        tx(8'h90); tx(8'hF8); tx(8'h40); tx(8'hFE); tx(8'h7F); idle();
        voice("rt", 64, 1, 127, 4);

        tx(8'hB0); tx(8'h70); tx(8'h03); idle();
        chk("cc.form", int'(form), 3);
        tx(8'hB0); tx(8'h71); tx(8'h10); idle();
        chk("cc.pw", int'(pulse_width), 16);
        chk("cc.form_kept", int'(form), 3);
        tx(8'h91); tx(8'h30); tx(8'h40); idle();
        voice("chan1", 64, 1, 127, 4);
        tx(8'hC0); tx(8'h05); tx(8'h90); tx(8'h30); tx(8'h40); idle();
        voice("pc_on", 48, 1, 64, 5);

        tx(8'h90); tx(8'h45); tx(8'hB0); tx(8'h71); tx(8'h20); idle();
        chk("abort.pw", int'(pulse_width), 32);
        voice("abort", 48, 1, 64, 5);

        tx(8'h80); tx(8'h30); tx(8'h00); idle();
        voice("off_match", 48, 0, 64, 6);

        tx(8'h90); tx(8'h45); tx(8'hF6); tx(8'h3C); tx(8'h50); idle();
        voice("syscom", 48, 0, 64, 6);

        tx(8'h90); tx(8'h45);
        @(negedge CLK);
        rx_valid = 1'b0;
        RESET    = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        strb  = 0;
        tx(8'h64); idle();
        voice("rst_mid", 69, 0, 0, 0);
        chk("rst_mid.pw", int'(pulse_width), 40);
        chk("rst_mid.form", int'(form), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
